// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus one-at-a-time transmit sequencer feeding uart_tx (datain/wrsig/idle).
// Optional define UART_TX_FIFO_WR_EDGE_EN: enqueue only on the rising edge of wr_en.
module uart_tx_fifo #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_en,
  input  logic                  ovf_clr,
  input  logic                  tx_busy,
  output logic [DATA_W-1:0]     tx_data,
  output logic                  tx_wrsig,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned TW    = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [TW-1:0]         TO_ONE   = TW'(1);
  localparam logic [TW-1:0]         TO_LAST  = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT_BUSY, WAIT_DONE} state_e;

  state_e                  state_q, state_d;
  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    full_q, empty_q;
  logic                    ovf_q, ovf_d;
  logic [DATA_W-1:0]       tx_data_q, tx_data_d;
  logic                    tx_wrsig_q, tx_wrsig_d;
  logic [TW-1:0]           to_cnt_q, to_cnt_d;
  logic                    wr_req, wr_acc, pop;

`ifdef UART_TX_FIFO_WR_EDGE_EN
  logic wr_en_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_en_q <= 1'b0;
    else        wr_en_q <= wr_en;
  end
  assign wr_req = wr_en & ~wr_en_q;
`else
  assign wr_req = wr_en;
`endif

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_wrsig_d = 1'b0;
    to_cnt_d   = to_cnt_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty_q && !tx_busy) begin
          pop       = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          state_d   = LOAD;
        end
      end
      LOAD: begin
        tx_wrsig_d = 1'b1;
        state_d    = STROBE;
      end
      STROBE: begin
        to_cnt_d = '0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A transmitter that never acknowledges is abandoned; the byte is not retried.
        if (tx_busy)                  state_d  = WAIT_DONE;
        else if (to_cnt_q == TO_LAST) state_d  = IDLE;
        else                          to_cnt_d = to_cnt_q + TO_ONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop frees a slot in the same cycle, so a write to a full FIFO is taken then.
  always_comb begin
    wr_acc  = wr_req && (!full_q || pop);
    count_d = count_q;
    if (wr_acc && !pop)      count_d = count_q + CNT_ONE;
    else if (!wr_acc && pop) count_d = count_q - CNT_ONE;
    ovf_d = ovf_q;
    if (wr_req && !wr_acc) ovf_d = 1'b1;
    else if (ovf_clr)      ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_wrsig_q <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)    rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q    <= count_d;
      full_q     <= (count_d == CNT_FULL);
      empty_q    <= (count_d == '0);
      ovf_q      <= ovf_d;
      tx_data_q  <= tx_data_d;
      tx_wrsig_q <= tx_wrsig_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_wrsig = tx_wrsig_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed + randomized bench for uart_tx_fifo against a queue-based transfer model
// and a simple uart_tx busy responder.
module tb_uart_tx_fifo;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned DEPTH_LOG2   = 4;
  localparam int unsigned BUSY_TIMEOUT = 4;
  localparam int unsigned DEPTH        = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_en;
  logic                ovf_clr;
  logic                tx_busy;
  logic [DATA_W-1:0]   tx_data;
  logic                tx_wrsig;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DATA_W      (DATA_W),
    .DEPTH_LOG2  (DEPTH_LOG2),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .ovf_clr (ovf_clr),
    .tx_busy (tx_busy),
    .tx_data (tx_data),
    .tx_wrsig(tx_wrsig),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference: queued bytes, sticky overflow, and progress of the current handshake.
  logic [7:0] m_q[$];
  logic       m_ovf;
  logic [7:0] m_data;
  bit         m_active;
  int         m_age;
  bit         m_rose;
  int         m_miss;
  logic       m_prev_wr;

  // Transmitter stand-in: 0 = busy for busy_len after each strobe, 1 = stuck low, 2 = stuck high.
  int         busy_mode;
  int         busy_len;
  int         busy_left;
  bit         strobe_prev;
  int         cyc;
  int         strobe_cyc[$];
  logic [7:0] rx_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0; m_data = 8'h00; m_active = 0; m_age = 0; m_rose = 0; m_miss = 0;
    m_prev_wr = 1'b0;
  endtask

  task automatic model_edge();
    bit pop, wreq, drop;
    pop = 0; drop = 0;
`ifdef UART_TX_FIFO_WR_EDGE_EN
    wreq = wr_en && !m_prev_wr;
`else
    wreq = wr_en;
`endif
    m_prev_wr = wr_en;
    if (!m_active) begin
      if (m_q.size() > 0 && !tx_busy) begin
        pop = 1; m_active = 1; m_age = 0; m_rose = 0; m_miss = 0;
      end
    end else if (m_age < 2) begin
      m_age++;
    end else if (!m_rose) begin
      if (tx_busy) m_rose = 1;
      else begin
        m_miss++;
        if (m_miss == int'(BUSY_TIMEOUT)) m_active = 0;
      end
    end else if (!tx_busy) begin
      m_active = 0;
    end
    if (pop) m_data = m_q.pop_front();
    if (wreq) begin
      if (m_q.size() < int'(DEPTH)) m_q.push_back(wr_data);
      else drop = 1;
    end
    if (drop)         m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
  endtask

  task automatic check_outputs();
    chk("count",    32'(count),    32'(m_q.size()));
    chk("empty",    32'(empty),    32'(m_q.size() == 0));
    chk("full",     32'(full),     32'(m_q.size() == int'(DEPTH)));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("tx_wrsig", 32'(tx_wrsig), 32'(m_active && m_age == 1));
    chk("tx_data",  32'(tx_data),  32'(m_data));
  endtask

  task automatic set_mode(input int mode, input int len);
    busy_mode = mode; busy_len = len; busy_left = 0;
    tx_busy = (mode == 2);
  endtask

  task automatic env_step();
    if (tx_wrsig === 1'b1) begin
      strobe_cyc.push_back(cyc);
      rx_q.push_back(tx_data);
    end
    if (busy_mode == 0) begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
      if (strobe_prev) begin
        tx_busy   = 1'b1;
        busy_left = (busy_len == 0) ? int'($urandom_range(1, 12)) : busy_len;
      end
    end
    strobe_prev = (tx_wrsig === 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check_outputs();
    env_step();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_data = b; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_wrsig"}, 32'(tx_wrsig), 32'd0);
    chk({tag, "_count"},    32'(count),    32'd0);
    chk({tag, "_empty"},    32'(empty),    32'd1);
    chk({tag, "_full"},     32'(full),     32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_tx_data"},  32'(tx_data),  32'd0);
  endtask

  initial begin
    logic [31:0] v;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; ovf_clr = 1'b0;
    cyc = 0; strobe_prev = 0;
    model_reset();
    set_mode(1, 0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Reset in the middle of a burst while a frame is in flight
    set_mode(0, 50);
    write_byte(8'hA1); write_byte(8'hA2); write_byte(8'hA3); write_byte(8'hA4);
    chk("pre_rst_count", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    model_reset();
    set_mode(1, 0);
    strobe_prev = 0;
    #2 rst_n = 1'b1;
    strobe_cyc.delete();
    run(12);
    chk("post_rst_no_strobe", 32'(strobe_cyc.size()), 32'd0);

    // Single byte latency
    set_mode(0, 10);
    wr_data = 8'h55; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("t2_count_N", 32'(count), 32'd1);
    tick();
    chk("t2_data_N1",  32'(tx_data),  32'h55);
    chk("t2_empty_N1", 32'(empty),    32'd1);
    chk("t2_wrsig_N1", 32'(tx_wrsig), 32'd0);
    tick();
    chk("t2_wrsig_N2", 32'(tx_wrsig), 32'd1);
    tick();
    chk("t2_wrsig_N3", 32'(tx_wrsig), 32'd0);
    run(20);

    // Burst of three
    set_mode(0, 6);
    rx_q.delete();
    for (int i = 1; i <= 3; i++) begin
      wr_data = 8'(i); wr_en = 1'b1;
      tick();
`ifdef UART_TX_FIFO_WR_EDGE_EN
      wr_en = 1'b0;
      tick();
`endif
    end
    wr_en = 1'b0;
    run(60);
    chk("t3_rx_n", 32'(rx_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      v = '1;
      if (i < rx_q.size()) v = 32'(rx_q[i]);
      chk("t3_rx_byte", v, 32'(i + 1));
    end

    // Fill, overflow, clear, drain
    set_mode(2, 0);
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    chk("t4_full",  32'(full),  32'd1);
    chk("t4_count", 32'(count), 32'd16);
    write_byte(8'hAA);
    chk("t4_ovf_set",  32'(overflow), 32'd1);
    chk("t4_count_dr", 32'(count),    32'd16);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", 32'(overflow), 32'd0);
    rx_q.delete();
    set_mode(0, 3);
    run(220);
    chk("t4_rx_n", 32'(rx_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      v = '1;
      if (i < rx_q.size()) v = 32'(rx_q[i]);
      chk("t4_rx_byte", v, 32'(i));
    end

    // Handshake timeout with tx_busy stuck low
    set_mode(1, 0);
    strobe_cyc.delete();
    write_byte(8'h11); write_byte(8'h22);
    run(30);
    chk("t5_strobes", 32'(strobe_cyc.size()), 32'd2);
    v = '1;
    if (strobe_cyc.size() == 2) v = 32'(strobe_cyc[1] - strobe_cyc[0]);
    chk("t5_gap", v, 32'(BUSY_TIMEOUT + 3));

    // Write into a full FIFO on the cycle of the pop
    set_mode(2, 0);
    for (int i = 0; i < 16; i++) write_byte(8'(8'h40 + i));
    chk("t5b_full", 32'(count), 32'd16);
    rx_q.delete();
    set_mode(0, 4);
    wr_data = 8'h99; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("t5b_count", 32'(count),    32'd16);
    chk("t5b_ovf",   32'(overflow), 32'd0);
    run(250);
    chk("t5b_rx_n", 32'(rx_q.size()), 32'd17);
    for (int i = 0; i < 17; i++) begin
      v = '1;
      if (i < rx_q.size()) v = 32'(rx_q[i]);
      chk("t5b_rx_byte", v, (i < 16) ? 32'(8'h40 + i) : 32'h99);
    end

    // Held wr_en level
    set_mode(2, 0);
    wr_data = 8'h3C; wr_en = 1'b1;
    run(5);
    wr_en = 1'b0;
    tick();
`ifdef UART_TX_FIFO_WR_EDGE_EN
    chk("t6_count", 32'(count), 32'd1);
`else
    chk("t6_count", 32'(count), 32'd5);
`endif
    set_mode(0, 2);
    run(80);

    // Randomized traffic, then drain
    set_mode(0, 0);
    for (int i = 0; i < 700; i++) begin
      wr_en   = ($urandom_range(0, 99) < 45);
      wr_data = 8'($urandom);
      ovf_clr = ($urandom_range(0, 24) == 0);
      tick();
    end
    wr_en = 1'b0; ovf_clr = 1'b0;
    run(400);
    chk("rand_drained", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
